// File: rtl/alu_mcycle.sv
// Registered integer ALU for the EX stage.
// Single-cycle ADD/SUB/AND/ORR/ADC/SBC. Iterative MUL (shift-add) and UDIV (restoring).
// Start/Busy/Done handshake. ARM-style {N,Z,C,V} flags.
module alu_mcycle #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] Src_A,
   input  logic [WIDTH-1:0] Src_B,
   input  logic             C_In,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ALUResult,
   output logic [3:0]       ALUFlags
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned SUM_W = WIDTH + 1;
   localparam int unsigned MSB   = WIDTH - 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_ORR  = 3'b011;
   localparam logic [2:0] OP_ADC  = 3'b100;
   localparam logic [2:0] OP_SBC  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_UDIV = 3'b111;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             is_div_q;
   // MUL: accumulator / multiplicand / multiplier. UDIV: remainder / dividend->quotient / divisor.
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;

   logic [WIDTH-1:0] bx_c;
   logic             cin_c;
   logic [SUM_W-1:0] sum_c;
   logic [WIDTH-1:0] sc_res_c;
   logic             sc_c_c;
   logic             sc_v_c;
   logic             multi_c;

   logic [WIDTH-1:0] mul_acc_c;
   logic [SUM_W-1:0] rem_sh_c;
   logic [SUM_W-1:0] diff_c;
   logic             qbit_c;
   logic [WIDTH-1:0] rem_c;
   logic [WIDTH-1:0] quo_c;
   logic [WIDTH-1:0] calc_res_c;

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign ALUResult = result_q;
   assign ALUFlags  = flags_q;

   function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] res, input logic c, input logic v);
      return {res[MSB], (res == '0), c, v};
   endfunction

   // Single-cycle datapath evaluated on live inputs at the accepting edge
   always_comb begin
      bx_c     = Src_B;
      cin_c    = 1'b0;
      sc_res_c = '0;
      sc_c_c   = 1'b0;
      sc_v_c   = 1'b0;
      case (ALUControl)
         OP_SUB:  begin bx_c = ~Src_B; cin_c = 1'b1; end
         OP_ADC:  begin cin_c = C_In; end
         OP_SBC:  begin bx_c = ~Src_B; cin_c = C_In; end
         default: ;
      endcase
      sum_c = {1'b0, Src_A} + {1'b0, bx_c} + SUM_W'(cin_c);
      case (ALUControl)
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            sc_res_c = sum_c[WIDTH-1:0];
            sc_c_c   = sum_c[WIDTH];
            sc_v_c   = ~(Src_A[MSB] ^ bx_c[MSB]) & (Src_A[MSB] ^ sum_c[MSB]);
         end
         OP_AND:  sc_res_c = Src_A & Src_B;
         OP_ORR:  sc_res_c = Src_A | Src_B;
         OP_UDIV: begin
            // only reached for a zero divisor
            sc_res_c = '1;
            sc_v_c   = 1'b1;
         end
         default: ;
      endcase
      multi_c = (ALUControl == OP_MUL) || ((ALUControl == OP_UDIV) && (Src_B != '0));
   end

   // One iteration step of the multiplier and the restoring divider
   always_comb begin
      mul_acc_c  = opb_q[0] ? (acc_q + opa_q) : acc_q;
      rem_sh_c   = {acc_q, opa_q[MSB]};
      diff_c     = rem_sh_c - {1'b0, opb_q};
      qbit_c     = ~diff_c[WIDTH];
      rem_c      = qbit_c ? diff_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
      quo_c      = {opa_q[WIDTH-2:0], qbit_c};
      calc_res_c = is_div_q ? quo_c : mul_acc_c;
   end

   // Control FSM, iteration registers and registered outputs
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         acc_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_CALC: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (is_div_q) begin
                  acc_q <= rem_c;
                  opa_q <= quo_c;
               end else begin
                  acc_q <= mul_acc_c;
                  opa_q <= opa_q << 1;
                  opb_q <= opb_q >> 1;
               end
               if (cnt_q == LAST_ITER) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= calc_res_c;
                  flags_q  <= mk_flags(calc_res_c, 1'b0, 1'b0);
               end
            end
            default: begin
               if (Start) begin
                  if (multi_c) begin
                     state_q  <= S_CALC;
                     busy_q   <= 1'b1;
                     cnt_q    <= '0;
                     is_div_q <= (ALUControl == OP_UDIV);
                     acc_q    <= '0;
                     opa_q    <= Src_A;
                     opb_q    <= Src_B;
                  end else begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     result_q <= sc_res_c;
                     flags_q  <= mk_flags(sc_res_c, sc_c_c, sc_v_c);
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
